// File: rtl/seg_pkg.sv
// Shared constants and elaboration helpers for the multiplexed seven-segment driver.
package seg_pkg;

    // Segment bit positions; bit set means segment lit (active-high domain).
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] BLANK_SEGS = 7'h7F;

    // Bits needed to hold 0..v-1, never less than one so degenerate sizes stay legal.
    function automatic int seg_clog2(input int v);
        int w;
        w = 1;
        while ((1 << w) < v) w++;
        return w;
    endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex-to-seven-segment decoder, active-high, bit SEG_A..SEG_G = a..g.
module hex7seg_dec
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = '0;
        case (hex)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
        endcase
    end

endmodule

// File: rtl/seg_scan_drvr.sv
// Multiplexed common-anode seven-segment scanner with decimal points, leading-zero
// blanking, PWM brightness and per-digit blink; all display pins come from flops.
module seg_scan_drvr
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000,
    parameter int BRIGHT_W   = 3,
    parameter int BLINK_DIV  = 250
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    input  logic [BRIGHT_W-1:0]     brightness,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              cath,
    output logic                    dp_n,
    output logic                    slot_tick
);

    localparam int PRE_W = seg_clog2(CLK_DIV);
    localparam int IDX_W = seg_clog2(NUM_DIGITS);
    localparam int BLK_W = seg_clog2(BLINK_DIV);

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_DIV - 1);

    logic [PRE_W-1:0]    prescaler;
    logic [IDX_W-1:0]    idx;
    logic [BRIGHT_W-1:0] pwm_cnt;
    logic [BLK_W-1:0]    blink_cnt;
    logic                blink_phase;
    logic                tick;

    logic [3:0]            cur_hex;
    logic [6:0]            seg_on;
    logic                  lead_zero;
    logic                  blank;
    logic [IDX_W-1:0]      an_sel;
    logic [NUM_DIGITS-1:0] an_next;

    logic [NUM_DIGITS-1:0] an_p1;
    logic [6:0]            cath_p1;
    logic                  dp_n_p1;
    logic                  slot_tick_p1;

    assign tick = (prescaler == '0);

    // Timing state: slot prescaler, digit index, PWM ramp and blink phase
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler   <= PRE_MAX;
            idx         <= '0;
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (tick) begin
                prescaler <= PRE_MAX;
                idx       <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
                if (blink_cnt == BLK_MAX) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end else begin
                prescaler <= prescaler - 1'b1;
            end
        end
    end

    hex7seg_dec u_dec (
        .hex (cur_hex),
        .seg (seg_on)
    );

    // Stage p0: select current digit and decide whether it is blanked
    always_comb begin
        cur_hex   = digits[{idx, 2'b00} +: 4];
        lead_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i <= int'(idx) && digits[4*i +: 4] != 4'h0) lead_zero = 1'b0;
        end
        blank = (blink_phase && blink_en[idx])
             || (blank_lz && (idx != IDX_MAX) && lead_zero)
             || (pwm_cnt > brightness);
        an_sel          = IDX_MAX - idx;
        an_next         = '1;
        an_next[an_sel] = 1'b0;
    end

    // Stage p1: registered pin drive
    always_ff @(posedge clk) begin
        if (rst) begin
            an_p1        <= '1;
            cath_p1      <= BLANK_SEGS;
            dp_n_p1      <= 1'b1;
            slot_tick_p1 <= 1'b0;
        end else begin
            slot_tick_p1 <= tick;
            if (blank) begin
                an_p1   <= '1;
                cath_p1 <= BLANK_SEGS;
                dp_n_p1 <= 1'b1;
            end else begin
                an_p1   <= an_next;
                cath_p1 <= ~seg_on;
                dp_n_p1 <= ~dp_in[idx];
            end
        end
    end

    assign an        = an_p1;
    assign cath      = cath_p1;
    assign dp_n      = dp_n_p1;
    assign slot_tick = slot_tick_p1;

endmodule

// File: tb/tb_seg_scan_drvr.sv
// Directed bench for seg_scan_drvr with NUM_DIGITS=4, CLK_DIV=4, BRIGHT_W=2, BLINK_DIV=2.
module tb_seg_scan_drvr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic        blank_lz = 1'b0;
    logic [1:0]  brightness = 2'd3;
    logic [3:0]  blink_en = 4'h0;
    logic [3:0]  an;
    logic [6:0]  cath;
    logic        dp_n;
    logic        slot_tick;

    int vectors = 0;
    int miscompares = 0;

    // Active-low cathode patterns for hex 0..F, worked out by hand.
    logic [6:0] cath_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [3:0] scan_an [4]   = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    logic [3:0] lz_an [4]     = '{4'b1111, 4'b1111, 4'b1101, 4'b1110};
    logic [6:0] lz_cath [4]   = '{7'h7F, 7'h7F, 7'h12, 7'h40};
    logic [3:0] z_an [4]      = '{4'b1111, 4'b1111, 4'b1111, 4'b1110};
    logic [6:0] z_cath [4]    = '{7'h7F, 7'h7F, 7'h7F, 7'h40};

    seg_scan_drvr #(
        .NUM_DIGITS (4),
        .CLK_DIV    (4),
        .BRIGHT_W   (2),
        .BLINK_DIV  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .brightness (brightness),
        .blink_en   (blink_en),
        .an         (an),
        .cath       (cath),
        .dp_n       (dp_n),
        .slot_tick  (slot_tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        // Reset state, then plain scan of 3210 at full brightness
        digits = 16'h3210;
        reset_dut();
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_cath", 32'(cath), 32'h7F);
        chk("rst_dp", 32'(dp_n), 32'h1);
        chk("rst_tick", 32'(slot_tick), 32'h0);
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("scan_an", 32'(an), 32'(scan_an[(k-1)/4]));
            chk("scan_cath", 32'(cath), 32'(cath_tab[(k-1)/4]));
            chk("scan_dp", 32'(dp_n), 32'h1);
            chk("scan_tick", 32'(slot_tick), (k % 4 == 0) ? 32'h1 : 32'h0);
        end

        // Leading-zero suppression
        digits   = 16'h0500;
        blank_lz = 1'b1;
        reset_dut();
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("lz_an", 32'(an), 32'(lz_an[(k-1)/4]));
            chk("lz_cath", 32'(cath), 32'(lz_cath[(k-1)/4]));
        end
        digits = 16'h0000;
        reset_dut();
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("lz0_an", 32'(an), 32'(z_an[(k-1)/4]));
            chk("lz0_cath", 32'(cath), 32'(z_cath[(k-1)/4]));
        end
        blank_lz = 1'b0;

        // Brightness 1 (50%) then 0 (25%)
        digits     = 16'h3210;
        brightness = 2'd1;
        reset_dut();
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("pwm1_an", 32'(an), ((k-1) % 4 <= 1) ? 32'(scan_an[(k-1)/4]) : 32'hF);
            chk("pwm1_cath", 32'(cath), ((k-1) % 4 <= 1) ? 32'(cath_tab[(k-1)/4]) : 32'h7F);
        end
        brightness = 2'd0;
        reset_dut();
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("pwm0_an", 32'(an), ((k-1) % 4 == 0) ? 32'(scan_an[(k-1)/4]) : 32'hF);
        end
        brightness = 2'd3;

        // Blink and decimal point: phase is 1 during slots 2,3 of each scan
        dp_in    = 4'b0100;
        blink_en = 4'b0010;
        reset_dut();
        for (int k = 1; k <= 32; k++) begin
            step();
            chk("bl1_an", 32'(an), 32'(scan_an[((k-1)/4) % 4]));
            chk("bl1_dp", 32'(dp_n), (((k-1)/4) % 4 == 2) ? 32'h0 : 32'h1);
        end
        blink_en = 4'b1111;
        reset_dut();
        for (int k = 1; k <= 32; k++) begin
            step();
            if ((((k-1)/4)/2) % 2 == 0) begin
                chk("blon_an", 32'(an), 32'(scan_an[((k-1)/4) % 4]));
                chk("blon_cath", 32'(cath), 32'(cath_tab[((k-1)/4) % 4]));
                chk("blon_dp", 32'(dp_n), (((k-1)/4) % 4 == 2) ? 32'h0 : 32'h1);
            end else begin
                chk("bloff_an", 32'(an), 32'hF);
                chk("bloff_cath", 32'(cath), 32'h7F);
                chk("bloff_dp", 32'(dp_n), 32'h1);
            end
        end
        dp_in    = 4'h0;
        blink_en = 4'h0;

        // Reset mid-slot at idx=2, on the cycle a tick would otherwise fire
        reset_dut();
        for (int k = 1; k <= 11; k++) step();
        chk("mid_pre_an", 32'(an), 32'b1101);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_an", 32'(an), 32'hF);
        chk("mid_cath", 32'(cath), 32'h7F);
        chk("mid_dp", 32'(dp_n), 32'h1);
        chk("mid_tick", 32'(slot_tick), 32'h0);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("post_an", 32'(an), 32'(scan_an[(k-1)/4]));
            chk("post_tick", 32'(slot_tick), (k % 4 == 0) ? 32'h1 : 32'h0);
        end

        // Hex decode sweep on digit0
        for (int d = 0; d < 16; d++) begin
            digits = {12'h000, 4'(d)};
            reset_dut();
            step();
            chk("hex_an", 32'(an), 32'b0111);
            chk("hex_cath", 32'(cath), 32'(cath_tab[d]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
